a23_copro_master: RTL

- Initiator side of the CP15 coprocessor interface.
- After `i_system_rdy` rises, it runs a fixed boot sequence of MCR writes to program the cache registers, then reads the ID register and checks it.
- After boot it serves single MCR/MRC commands from a control client (boot/debug controller) through a valid/ready handshake.
- It honours `i_fetch_stall` exactly as the coprocessor samples it.

---
 rtl/a23_copro_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/a23_copro_master.sv
// CP15 initiator: boots the cache registers, checks the ID register, then
// relays single MCR/MRC commands from a control client over valid/ready.
module a23_copro_master #(
    parameter logic [2:0]  BOOT_CACHE_CTRL = 3'b011,
    parameter logic [31:0] BOOT_CACHEABLE  = 32'h0000_0100,
    parameter logic [31:0] BOOT_UPDATEABLE = 32'h0000_0101,
    parameter logic [31:0] BOOT_DISRUPTIVE = 32'h0000_0000,
    parameter logic [31:0] EXPECT_ID       = 32'h4156_0300
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_system_rdy,
    input  logic        i_fetch_stall,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [3:0]  i_cmd_crn,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_boot_done,
    output logic        o_id_ok,
    output logic [1:0]  o_copro_operation,
    output logic [3:0]  o_copro_crn,
    output logic [3:0]  o_copro_crm,
    output logic [2:0]  o_copro_opcode1,
    output logic [2:0]  o_copro_opcode2,
    output logic [3:0]  o_copro_num,
    output logic [31:0] o_copro_write_data,
    input  logic [31:0] i_copro_read_data
);

    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_MRC  = 2'd1;
    localparam logic [1:0] OP_MCR  = 2'd2;
    localparam logic [2:0] LAST_STEP = 3'd5;

    typedef enum logic [2:0] {
        WAIT_RDY, BOOT, BOOT_CAP, IDLE, ISSUE, CAPTURE
    } state_t;

    state_t     state;
    logic [2:0] step;

    assign o_copro_crm     = 4'd0;
    assign o_copro_opcode1 = 3'd0;
    assign o_copro_opcode2 = 3'd0;
    assign o_copro_num     = 4'd15;

    // Boot order: flush first, region masks next, enable caches last, then ID read.
    function automatic logic [3:0] boot_crn(input logic [2:0] s);
        case (s)
            3'd0:    boot_crn = 4'd1;
            3'd1:    boot_crn = 4'd3;
            3'd2:    boot_crn = 4'd4;
            3'd3:    boot_crn = 4'd5;
            3'd4:    boot_crn = 4'd2;
            default: boot_crn = 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] boot_data(input logic [2:0] s);
        case (s)
            3'd1:    boot_data = BOOT_CACHEABLE;
            3'd2:    boot_data = BOOT_UPDATEABLE;
            3'd3:    boot_data = BOOT_DISRUPTIVE;
            3'd4:    boot_data = {29'd0, BOOT_CACHE_CTRL};
            default: boot_data = 32'd0;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state              <= WAIT_RDY;
            step               <= 3'd0;
            o_cmd_ready        <= 1'b0;
            o_rsp_valid        <= 1'b0;
            o_rsp_rdata        <= 32'd0;
            o_boot_done        <= 1'b0;
            o_id_ok            <= 1'b0;
            o_copro_operation  <= OP_IDLE;
            o_copro_crn        <= 4'd0;
            o_copro_write_data <= 32'd0;
        end else begin
            o_rsp_valid <= 1'b0;
            // Losing system ready resets the coprocessor, so anything in flight is dropped.
            if (state != WAIT_RDY && !i_system_rdy) begin
                state             <= WAIT_RDY;
                o_copro_operation <= OP_IDLE;
                o_cmd_ready       <= 1'b0;
                o_boot_done       <= 1'b0;
                o_id_ok           <= 1'b0;
            end else begin
                case (state)
                    WAIT_RDY: if (i_system_rdy) begin
                        state              <= BOOT;
                        step               <= 3'd0;
                        o_copro_operation  <= OP_MCR;
                        o_copro_crn        <= boot_crn(3'd0);
                        o_copro_write_data <= boot_data(3'd0);
                    end
                    BOOT: if (!i_fetch_stall) begin
                        if (step == LAST_STEP) begin
                            state             <= BOOT_CAP;
                            o_copro_operation <= OP_IDLE;
                        end else begin
                            step               <= step + 3'd1;
                            o_copro_operation  <= (step + 3'd1 == LAST_STEP) ? OP_MRC : OP_MCR;
                            o_copro_crn        <= boot_crn(step + 3'd1);
                            o_copro_write_data <= boot_data(step + 3'd1);
                        end
                    end
                    BOOT_CAP: begin
                        o_id_ok     <= (i_copro_read_data == EXPECT_ID);
                        o_boot_done <= 1'b1;
                        o_cmd_ready <= 1'b1;
                        state       <= IDLE;
                    end
                    IDLE: if (i_cmd_valid && o_cmd_ready) begin
                        o_cmd_ready        <= 1'b0;
                        o_copro_operation  <= i_cmd_write ? OP_MCR : OP_MRC;
                        o_copro_crn        <= i_cmd_crn;
                        o_copro_write_data <= i_cmd_wdata;
                        state              <= ISSUE;
                    end
                    ISSUE: if (!i_fetch_stall) begin
                        o_copro_operation <= OP_IDLE;
                        if (o_copro_operation == OP_MCR) begin
                            o_rsp_valid <= 1'b1;
                            o_cmd_ready <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        // Read data is registered by the coprocessor, so it is valid here even under stall.
                        o_rsp_rdata <= i_copro_read_data;
                        o_rsp_valid <= 1'b1;
                        o_cmd_ready <= 1'b1;
                        state       <= IDLE;
                    end
                    default: state <= WAIT_RDY;
                endcase
            end
        end
    end

endmodule
